// File: rtl/score_display_pkg.sv
// Shared definitions for the score display slice.
//   GLYPH_DASH    - glyph code of the dash shown on overflow (codes 0..9 are digits)
//   conv_state_t  - binary-to-BCD converter states
//   dabble()      - double-dabble per-digit adjust
//   glyph_base()  - first ROM word of a glyph; glyphs are stored back to back
package score_display_pkg;

    localparam logic [3:0] GLYPH_DASH = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic int unsigned glyph_base(input logic [3:0] code, input int unsigned height);
        return 32'(code) * height;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Ports:
//   clk    in   pixel clock
//   rst    in   asynchronous active-low reset
//   start  in   load bin and begin; honoured only while idle
//   bin    in   NUM_W-bit value to convert
//   busy   out  conversion in progress (SHIFT or DONE)
//   done   out  1-cycle result-valid strobe
//   bcd    out  DIGITS packed BCD digits, digit 0 in the low nibble
//   ovf    out  bin did not fit in DIGITS decimal digits
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int unsigned NUM_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

    conv_state_t          state, state_nxt;
    logic [NUM_W-1:0]     shreg;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  adj;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_r;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(NUM_W - 1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = dabble(acc[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf_r <= (64'(bin) >= LIMIT);
                    end
                end
                ST_SHIFT: begin
                    // Digits beyond DIGITS are dropped; ovf overrides the result then.
                    acc   <= {adj[4*DIGITS-2:0], shreg[NUM_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign bcd  = acc;
    assign ovf  = ovf_r;

endmodule

// File: rtl/score_display.sv
// Score display: draws an unsigned value as DIGITS glyphs on the VGA raster.
// Converts the value to BCD sequentially, then fetches glyph rows from the
// shared synchronous character ROM and produces a registered 1-bit pixel mask.
// Optional build macro: SCORE_LZB_EN (leading-zero blanking; rightmost digit
// always drawn; overflow dashes never blanked).
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous active-low reset
//   number      in   value to display
//   number_vld  in   1-cycle load strobe
//   busy        out  conversion in progress or a value pending
//   posx/posy   in   top-left corner of the field
//   x/y         in   current raster position
//   rom_adr     out  registered character ROM address
//   rom_data    in   ROM row, 1 clk after rom_adr; MSB is leftmost pixel
//   dout        out  registered pixel mask, 2 clks after x/y are sampled
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned NUM_W  = 14,
    parameter int unsigned CHAR_W = 32,
    parameter int unsigned CHAR_H = 32,
    parameter int unsigned ROM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_W-1:0]  number,
    input  logic              number_vld,
    output logic              busy,
    input  logic [9:0]        posx,
    input  logic [9:0]        posy,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    output logic [ROM_AW-1:0] rom_adr,
    input  logic [CHAR_W-1:0] rom_data,
    output logic              dout
);

    localparam int unsigned CW_L  = $clog2(CHAR_W);
    localparam int unsigned BOX_W = DIGITS * CHAR_W;

    // ---------------- converter, pending slot, shown register ----------------
    logic                 conv_busy;
    logic                 conv_done;
    logic                 conv_ovf;
    logic                 conv_start;
    logic [NUM_W-1:0]     conv_bin;
    logic [4*DIGITS-1:0]  conv_bcd;
    logic                 pend_vld;
    logic [NUM_W-1:0]     pend_val;
    logic [4*DIGITS-1:0]  shown_bcd;
    logic                 shown_ovf;

    // A pending value takes priority; a strobe in the same idle cycle is parked.
    assign conv_start = !conv_busy && (pend_vld || number_vld);
    assign conv_bin   = pend_vld ? pend_val : number;

    bin2bcd_seq #(
        .NUM_W  (NUM_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld  <= 1'b0;
            pend_val  <= '0;
            shown_bcd <= '0;
            shown_ovf <= 1'b0;
        end else begin
            if (conv_start && pend_vld) pend_vld <= 1'b0;
            if (number_vld && (conv_busy || pend_vld)) begin
                pend_vld <= 1'b1;
                pend_val <= number;
            end
            if (conv_done) begin
                shown_bcd <= conv_bcd;
                shown_ovf <= conv_ovf;
            end
        end
    end

    // Pending counts as busy so the flag stays high across back-to-back runs.
    assign busy = conv_busy | pend_vld;

    // ---------------- glyph decode (position 0 is leftmost) ----------------
    logic [3:0]        digit [DIGITS];
    logic [DIGITS-1:0] lead_blank;

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit[i] = shown_bcd[4*(DIGITS-1-i) +: 4];
        end
    end

`ifdef SCORE_LZB_EN
    logic seen_nz;
    always_comb begin
        lead_blank = '0;
        seen_nz    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!seen_nz && (i != DIGITS - 1) && !shown_ovf && (digit[i] == 4'd0))
                lead_blank[i] = 1'b1;
            seen_nz = seen_nz | (digit[i] != 4'd0);
        end
    end
`else
    always_comb begin
        lead_blank = '0;
    end
`endif

    // ---------------- pixel pipeline ----------------
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [10:0]       dsel;
    logic              inbox;
    logic [3:0]        sel_code;
    logic              sel_blank;
    logic [ROM_AW-1:0] glyph_adr;

    // Unsigned wrap makes a raster position left/above the field look huge.
    assign dx    = x - 11'(posx);
    assign dy    = y - 11'(posy);
    assign dsel  = dx >> CW_L;
    assign inbox = (dx < 11'(BOX_W)) && (dy < 11'(CHAR_H));

    always_comb begin
        sel_code  = '0;
        sel_blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dsel == 11'(i)) begin
                sel_code  = shown_ovf ? GLYPH_DASH : digit[i];
                sel_blank = lead_blank[i];
            end
        end
    end

    assign glyph_adr = ROM_AW'(glyph_base(sel_code, CHAR_H)) + ROM_AW'(dy);

    logic            inbox_s0, inbox_d1;
    logic            blank_s0, blank_d1;
    logic [CW_L-1:0] col_s0,   col_d1;
    logic [CW_L-1:0] bit_sel;

    // CHAR_W is a power of two, so CHAR_W-1-col is the bitwise complement.
    assign bit_sel = ~col_d1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_adr  <= '0;
            inbox_s0 <= 1'b0;
            blank_s0 <= 1'b0;
            col_s0   <= '0;
            inbox_d1 <= 1'b0;
            blank_d1 <= 1'b0;
            col_d1   <= '0;
            dout     <= 1'b0;
        end else begin
            if (inbox) rom_adr <= glyph_adr;
            inbox_s0 <= inbox;
            blank_s0 <= sel_blank;
            col_s0   <= dx[CW_L-1:0];
            inbox_d1 <= inbox_s0;
            blank_d1 <= blank_s0;
            col_d1   <= col_s0;
            dout     <= inbox_d1 & ~blank_d1 & rom_data[bit_sel];
        end
    end

endmodule
